// File: rtl/sram_fifo_pkg.sv
// rtl/sram_fifo_pkg.sv - shared defaults and constants for the SRAM-backed FIFO controller
package sram_fifo_pkg;

  localparam int DW_DEF    = 64;
  localparam int AW_DEF    = 10;
  localparam int DEPTH_DEF = 1024;

  localparam logic [1:0] RTSEL_DEF = 2'b01;
  localparam logic [1:0] WTSEL_DEF = 2'b01;
  localparam logic [1:0] MTSEL_DEF = 2'b00;

  // BWEB is active-low per bit; zero on every bit means full-word writes
  localparam logic BWEB_BIT = 1'b0;

endpackage

// File: rtl/sram_fifo_obuf.sv
// rtl/sram_fifo_obuf.sv - 2-entry output buffer fed by SRAM read data, drained by a valid/ready pop
module sram_fifo_obuf #(
  parameter int DW = 64
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          wr_valid,
  input  logic [DW-1:0] wr_data,
  output logic          rd_valid,
  input  logic          rd_ready,
  output logic [DW-1:0] rd_data,
  output logic [1:0]    count
);

  logic [DW-1:0] mem0_q, mem0_d;
  logic [DW-1:0] mem1_q, mem1_d;
  logic          head_q, head_d;
  logic          tail_q, tail_d;
  logic [1:0]    cnt_q, cnt_d;
  logic          pop;

  assign rd_valid = (cnt_q != 2'd0);
  assign rd_data  = head_q ? mem1_q : mem0_q;
  assign count    = cnt_q;
  assign pop      = rd_valid & rd_ready;

  // Writer never checks space: the controller's read credit keeps occupancy <= 2
  always_comb begin
    mem0_d = mem0_q;
    mem1_d = mem1_q;
    head_d = head_q;
    tail_d = tail_q;
    cnt_d  = cnt_q + 2'(wr_valid) - 2'(pop);
    if (wr_valid) begin
      if (tail_q) mem1_d = wr_data;
      else        mem0_d = wr_data;
      tail_d = ~tail_q;
    end
    if (pop) head_d = ~head_q;
    if (clr) begin
      head_d = 1'b0;
      tail_d = 1'b0;
      cnt_d  = 2'd0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head_q <= 1'b0;
      tail_q <= 1'b0;
      cnt_q  <= 2'd0;
    end else begin
      head_q <= head_d;
      tail_q <= tail_d;
      cnt_q  <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    mem0_q <= mem0_d;
    mem1_q <= mem1_d;
  end

endmodule

// File: rtl/sram_fifo_ctrl.sv
// rtl/sram_fifo_ctrl.sv - streaming FIFO controller owning a 1024x64 two-port SRAM macro
module sram_fifo_ctrl
  import sram_fifo_pkg::*;
#(
  parameter int         DW        = DW_DEF,
  parameter int         AW        = AW_DEF,
  parameter int         DEPTH     = DEPTH_DEF,
  parameter logic [1:0] RTSEL_VAL = RTSEL_DEF,
  parameter logic [1:0] WTSEL_VAL = WTSEL_DEF,
  parameter logic [1:0] MTSEL_VAL = MTSEL_DEF
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          flush,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] in_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_data,
  output logic [AW:0]   level,
  output logic          empty,
  output logic          full,
  output logic [AW-1:0] sram_aa,
  output logic [DW-1:0] sram_d,
  output logic [DW-1:0] sram_bweb,
  output logic          sram_web,
  output logic [AW-1:0] sram_ab,
  output logic          sram_reb,
  input  logic [DW-1:0] sram_q,
  output logic [1:0]    sram_rtsel,
  output logic [1:0]    sram_wtsel,
  output logic [1:0]    sram_mtsel
);

  logic [AW-1:0] wptr_q, wptr_d;
  logic [AW-1:0] rptr_q, rptr_d;
  logic [AW:0]   cnt_q, cnt_d;
  logic          inflight_q, inflight_d;
  logic [1:0]    ob_cnt;
  logic [2:0]    occ_after_pop;
  logic          push, pop, rd;

  assign full      = (cnt_q == (AW+1)'(DEPTH));
  assign in_ready  = ~full;
  assign level     = cnt_q;
  assign empty     = (cnt_q == '0) & ~inflight_q & (ob_cnt == 2'd0);
  assign pop       = out_valid & out_ready;
  assign push      = in_valid & in_ready & ~flush & ~RST;

  // Credit counts this cycle's pop so a full-rate stream keeps one read in flight
  assign occ_after_pop = 3'(ob_cnt) + 3'(inflight_q) - 3'(pop);
  assign rd = (cnt_q != '0) & (occ_after_pop < 3'd2) & ~flush & ~RST;

  assign sram_web   = ~push;
  assign sram_aa    = wptr_q;
  assign sram_d     = in_data;
  assign sram_reb   = ~rd;
  assign sram_ab    = rptr_q;
  assign sram_bweb  = {DW{BWEB_BIT}};
  assign sram_rtsel = RTSEL_VAL;
  assign sram_wtsel = WTSEL_VAL;
  assign sram_mtsel = MTSEL_VAL;

  always_comb begin
    wptr_d     = wptr_q + AW'(push);
    rptr_d     = rptr_q + AW'(rd);
    cnt_d      = cnt_q + (AW+1)'(push) - (AW+1)'(rd);
    inflight_d = rd;
    if (flush) begin
      wptr_d     = '0;
      rptr_d     = '0;
      cnt_d      = '0;
      inflight_d = 1'b0;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      wptr_q     <= '0;
      rptr_q     <= '0;
      cnt_q      <= '0;
      inflight_q <= 1'b0;
    end else begin
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
      cnt_q      <= cnt_d;
      inflight_q <= inflight_d;
    end
  end

  // Q is valid during the cycle after a read issue; flush drops it
  sram_fifo_obuf #(.DW(DW)) u_obuf (
    .clk      (CLK),
    .rst      (RST),
    .clr      (flush),
    .wr_valid (inflight_q),
    .wr_data  (sram_q),
    .rd_valid (out_valid),
    .rd_ready (out_ready),
    .rd_data  (out_data),
    .count    (ob_cnt)
  );

endmodule

// File: tb/tb_sram_fifo_ctrl.sv
// tb/tb_sram_fifo_ctrl.sv - scoreboard bench for sram_fifo_ctrl with a behavioural macro model
module tb_sram_fifo_ctrl;

  localparam int DW    = 64;
  localparam int AW    = 10;
  localparam int DEPTH = 1024;

  logic          CLK, RST, flush;
  logic          in_valid, in_ready, out_valid, out_ready;
  logic [DW-1:0] in_data, out_data;
  logic [AW:0]   level;
  logic          empty, full;
  logic [AW-1:0] sram_aa, sram_ab;
  logic [DW-1:0] sram_d, sram_bweb, sram_q;
  logic          sram_web, sram_reb;
  logic [1:0]    sram_rtsel, sram_wtsel, sram_mtsel;

  sram_fifo_ctrl dut (
    .CLK(CLK), .RST(RST), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .level(level), .empty(empty), .full(full),
    .sram_aa(sram_aa), .sram_d(sram_d), .sram_bweb(sram_bweb), .sram_web(sram_web),
    .sram_ab(sram_ab), .sram_reb(sram_reb), .sram_q(sram_q),
    .sram_rtsel(sram_rtsel), .sram_wtsel(sram_wtsel), .sram_mtsel(sram_mtsel)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Macro model: write on edge when WEB low, Q valid the cycle after REB low
  logic [DW-1:0] mem [DEPTH];
  always @(posedge CLK) begin
    if (!sram_web) mem[sram_aa] <= sram_d;
    if (!sram_reb) sram_q <= mem[sram_ab];
  end

  int vectors = 0;
  int miscompares = 0;
  logic [DW-1:0] exp_q[$];
  int unsigned wcnt = 0, rcnt = 0, reads = 0, pops = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: records accepted pushes into the scoreboard, checks every pop and macro access
  always @(negedge CLK) begin
    check("bweb_zero", sram_bweb, 64'd0);
    check("timing_sel", {58'd0, sram_rtsel, sram_wtsel, sram_mtsel}, 64'b01_01_00);
    check("ready_vs_full", in_ready, !full);
    if (RST || flush) begin
      check("web_idle_on_clear", sram_web, 1);
      check("reb_idle_on_clear", sram_reb, 1);
      exp_q.delete();
      wcnt = 0; rcnt = 0; reads = 0; pops = 0;
    end else begin
      if (in_valid && in_ready) begin
        check("web_on_push", sram_web, 0);
        check("write_addr", sram_aa, 64'(wcnt % DEPTH));
        check("write_data", sram_d, in_data);
        exp_q.push_back(in_data);
        wcnt++;
      end else begin
        check("web_no_push", sram_web, 1);
      end
      if (!sram_reb) begin
        check("read_addr", sram_ab, 64'(rcnt % DEPTH));
        rcnt++;
        reads++;
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check("pop_unexpected", out_valid, 0);
        end else begin
          check("pop_data", out_data, exp_q.pop_front());
        end
        pops++;
      end
      check("outstanding_le2", 64'((reads - pops) <= 2), 1);
    end
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic check_reset_vals(input string tag);
    @(negedge CLK);
    check({tag, "_in_ready"}, in_ready, 1);
    check({tag, "_out_valid"}, out_valid, 0);
    check({tag, "_empty"}, empty, 1);
    check({tag, "_full"}, full, 0);
    check({tag, "_level"}, level, 0);
    check({tag, "_web"}, sram_web, 1);
    check({tag, "_reb"}, sram_reb, 1);
  endtask

  task automatic drain(input int bound);
    int n;
    n = 0;
    in_valid = 1'b0;
    out_ready = 1'b1;
    while (!(exp_q.size() == 0 && empty) && n < bound) begin
      tick();
      n++;
    end
    check("drain_in_time", 64'(n < bound), 1);
  endtask

  initial begin
    int p0, burst;
    RST = 1'b1; flush = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    tick(); tick();
    RST = 1'b0;
    check_reset_vals("reset");

    // Single push latency on an empty block
    tick();
    in_valid = 1'b1; in_data = 64'hDEAD_BEEF_0123_4567; out_ready = 1'b1;
    @(negedge CLK);
    check("lat_web", sram_web, 0);
    check("lat_aa", sram_aa, 0);
    tick(); in_valid = 1'b0;
    @(negedge CLK);
    check("lat_reb", sram_reb, 0);
    check("lat_ab", sram_ab, 0);
    check("lat_n1_valid", out_valid, 0);
    tick();
    @(negedge CLK);
    check("lat_n2_valid", out_valid, 0);
    tick();
    @(negedge CLK);
    check("lat_n3_valid", out_valid, 1);
    check("lat_n3_data", out_data, 64'hDEAD_BEEF_0123_4567);
    tick();
    @(negedge CLK);
    check("lat_empty_after", empty, 1);
    tick();

    // Fill with backpressure: two words prefetch into the buffer, then SRAM fills to DEPTH
    out_ready = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      in_valid = 1'b1; in_data = 64'(i);
      @(negedge CLK);
      check("fill_ready", in_ready, 1);
      tick();
    end
    in_valid = 1'b0;
    repeat (4) tick();
    @(negedge CLK);
    check("fill_level_1022", level, DEPTH - 2);
    check("fill_not_full", full, 0);
    check("fill_obuf_valid", out_valid, 1);
    for (int i = 0; i < 2; i++) begin
      tick();
      in_valid = 1'b1; in_data = 64'(DEPTH + i);
    end
    tick();
    in_valid = 1'b1; in_data = 64'hBAD;
    @(negedge CLK);
    check("full_level", level, DEPTH);
    check("full_flag", full, 1);
    check("full_in_ready", in_ready, 0);
    check("full_web_held", sram_web, 1);
    repeat (3) tick();
    @(negedge CLK);
    check("full_level_held", level, DEPTH);
    tick();
    drain(3000);

    // Continuous streaming with wrap; steady state must pop every cycle
    out_ready = 1'b1;
    p0 = 0;
    for (int i = 0; i < 3000; i++) begin
      in_valid = 1'b1; in_data = 64'(i + 5000);
      tick();
      if (i == 500) p0 = pops;
      if (i == 2500) check("stream_rate", pops - p0, 2000);
    end
    drain(100);

    // Random bursty push with random pop backpressure
    burst = 0;
    for (int i = 0; i < 800; i++) begin
      if (burst == 0) begin
        in_valid = 1'($urandom % 2);
        burst = $urandom_range(1, 12);
      end
      burst--;
      in_data = {$urandom, $urandom};
      out_ready = 1'($urandom % 2);
      tick();
    end
    drain(200);

    // Flush with one word buffered and one read in flight
    tick();
    out_ready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      in_valid = 1'b1; in_data = {$urandom, $urandom};
      tick();
    end
    in_valid = 1'b0;
    repeat (4) tick();
    out_ready = 1'b1;
    @(negedge CLK);
    check("pre_flush_reb", sram_reb, 0);
    tick();
    out_ready = 1'b0; flush = 1'b1;
    tick();
    flush = 1'b0;
    @(negedge CLK);
    check("flush_out_valid", out_valid, 0);
    check("flush_level", level, 0);
    check("flush_empty", empty, 1);
    repeat (3) tick();
    @(negedge CLK);
    check("flush_no_stale", out_valid, 0);
    tick();
    in_valid = 1'b1; in_data = 64'h1; out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    repeat (2) tick();
    @(negedge CLK);
    check("post_flush_first_valid", out_valid, 1);
    check("post_flush_first_data", out_data, 64'h1);
    tick();
    drain(50);

    // RST for one cycle mid-stream
    out_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      in_valid = 1'b1; in_data = {$urandom, $urandom};
      tick();
    end
    RST = 1'b1;
    tick();
    RST = 1'b0; in_valid = 1'b0;
    check_reset_vals("midrst");
    tick();
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1; in_data = 64'(i + 77);
      tick();
    end
    drain(50);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

endmodule
